// File: rtl/sonar_echo_timer_if.sv
// Echo-timer bus: count/start/echo in, trigger and measurement results out.
// The master side drives the counter and sensor; the slave is the timer.
interface sonar_echo_timer_if;
  logic [31:0] count;
  logic        start;
  logic        echo;
  logic        trig;
  logic        busy;
  logic [31:0] width;
  logic        valid;
  logic        timeout;

  modport master (
    output count, start, echo,
    input  trig, busy, width, valid, timeout
  );

  modport slave (
    input  count, start, echo,
    output trig, busy, width, valid, timeout
  );
endinterface

// File: rtl/sonar_echo_timer.sv
// Ultrasonic ranging front end: trigger pulse, echo wait, echo high-time
// measurement from timestamp differences on the free-running count bus.
module sonar_echo_timer #(
  parameter int TRIG_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 3000000
) (
  input logic               clk,
  input logic               rst,
  sonar_echo_timer_if.slave bus
);

  localparam logic [31:0] TrigLast = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] TmoLim   = 32'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT,
    S_MEAS
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] stamp_q, stamp_d;
  logic [31:0] width_q, width_d;
  logic        valid_q, valid_d;
  logic        tmo_q, tmo_d;
  logic        sync1_q, sync2_q, prev_q;
  logic [31:0] elapsed;
  logic        rise, fall;

  assign elapsed = bus.count - stamp_q;
  assign rise    = sync2_q & ~prev_q;
  assign fall    = ~sync2_q & prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      stamp_q <= '0;
      width_q <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stamp_q <= stamp_d;
      width_q <= width_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      sync1_q <= bus.echo;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    stamp_d = stamp_q;
    width_d = width_q;
    valid_d = 1'b0;
    tmo_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Stamp the count of the first TRIG cycle so trig lasts TRIG_CYCLES
        if (bus.start && !valid_q && !tmo_q) begin
          stamp_d = bus.count + 32'd1;
          state_d = S_TRIG;
        end
      end
      S_TRIG: begin
        if (elapsed >= TrigLast) begin
          stamp_d = bus.count;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rise) begin
          stamp_d = bus.count;
          state_d = S_MEAS;
        end else if (elapsed >= TmoLim) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_MEAS: begin
        if (fall) begin
          width_d = elapsed;
          valid_d = 1'b1;
          state_d = S_IDLE;
        end else if (elapsed >= TmoLim) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.trig    = (state_q == S_TRIG);
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.width   = width_q;
  assign bus.valid   = valid_q;
  assign bus.timeout = tmo_q;

endmodule

// File: tb/tb_sonar_echo_timer.sv
// Self-checking bench for sonar_echo_timer with a result scoreboard.
// Expected pulses are queued when stimulus is planned and popped on output.
module tb_sonar_echo_timer;

  localparam int TRIG = 10;
  localparam int TMO  = 200;

  typedef struct packed {
    logic        is_to;
    logic [31:0] w;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b1;
  logic [31:0] load_val = '0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] last_w = '0;
  exp_t        sb[$];

  sonar_echo_timer_if bif();

  sonar_echo_timer #(
    .TRIG_CYCLES(TRIG),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    bif.count <= load_en ? load_val : bif.count + 32'd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
  endtask

  task automatic wait_trig_fall(output int n);
    n = 0;
    while (bif.trig === 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_pulse(output int n, output bit got);
    n = 0;
    got = 1'b0;
    while (n < 2000 && !got) begin
      tick();
      n++;
      got = (bif.valid === 1'b1) || (bif.timeout === 1'b1);
    end
  endtask

  task automatic test_reset();
    bif.start = 1'b0;
    bif.echo  = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    load_en = 1'b0;
    n_checks++;
    if ({bif.trig, bif.busy, bif.valid, bif.timeout} !== 4'b0000)
      $display("FAIL rst_ctl: got %b want 0000",
               {bif.trig, bif.busy, bif.valid, bif.timeout});
    else n_pass++;
    n_checks++;
    if (bif.width !== 32'd0)
      $display("FAIL rst_width: got %0d want 0", bif.width);
    else n_pass++;
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_trig_rise_timeout();
    int n;
    bit got;
    exp_t e;
    do_start();
    sb.push_back('{1'b1, last_w});
    n_checks++;
    if (bif.busy !== 1'b1)
      $display("FAIL trig_busy: got %b want 1", bif.busy);
    else n_pass++;
    wait_trig_fall(n);
    n_checks++;
    if (n != TRIG)
      $display("FAIL trig_len: got %0d want %0d", n, TRIG);
    else n_pass++;
    wait_pulse(n, got);
    n_checks++;
    if (!got) $display("FAIL rise_to_pulse: got none want timeout");
    else begin
      n_pass++;
      e = sb.pop_front();
      n_checks++;
      if ({bif.valid, bif.timeout} !== {~e.is_to, e.is_to})
        $display("FAIL rise_to_kind: got %b want %b",
                 {bif.valid, bif.timeout}, {~e.is_to, e.is_to});
      else n_pass++;
      n_checks++;
      if (n != TMO)
        $display("FAIL rise_to_time: got %0d want %0d", n, TMO);
      else n_pass++;
      n_checks++;
      if (bif.width !== e.w || bif.busy !== 1'b0)
        $display("FAIL rise_to_width: got %0d busy %b want %0d busy 0",
                 bif.width, bif.busy, e.w);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_nominal();
    int n;
    bit got;
    exp_t e;
    do_start();
    sb.push_back('{1'b0, 32'd57});
    wait_trig_fall(n);
    repeat (20) tick();
    bif.echo = 1'b1;
    repeat (57) tick();
    bif.echo = 1'b0;
    wait_pulse(n, got);
    n_checks++;
    if (!got) $display("FAIL nom_pulse: got none want valid");
    else begin
      n_pass++;
      e = sb.pop_front();
      n_checks++;
      if ({bif.valid, bif.timeout} !== {~e.is_to, e.is_to})
        $display("FAIL nom_kind: got %b want %b",
                 {bif.valid, bif.timeout}, {~e.is_to, e.is_to});
      else n_pass++;
      n_checks++;
      if (bif.width !== e.w)
        $display("FAIL nom_width: got %0d want %0d", bif.width, e.w);
      else n_pass++;
      n_checks++;
      if (bif.busy !== 1'b0)
        $display("FAIL nom_busy: got %b want 0", bif.busy);
      else n_pass++;
      last_w = e.w;
    end
    tick();
    n_checks++;
    if (bif.valid !== 1'b0)
      $display("FAIL nom_one_cycle: got %b want 0", bif.valid);
    else n_pass++;
  endtask

  task automatic test_echo_timeouts();
    int n;
    bit got;
    exp_t e;
    do_start();
    sb.push_back('{1'b1, last_w});
    wait_trig_fall(n);
    bif.echo = 1'b1;
    wait_pulse(n, got);
    n_checks++;
    if (!got) $display("FAIL meas_to_pulse: got none want timeout");
    else begin
      n_pass++;
      e = sb.pop_front();
      n_checks++;
      if ({bif.valid, bif.timeout} !== {~e.is_to, e.is_to} || n != TMO + 3)
        $display("FAIL meas_to: got %b at %0d want %b at %0d",
                 {bif.valid, bif.timeout}, n, {~e.is_to, e.is_to}, TMO + 3);
      else n_pass++;
      n_checks++;
      if (bif.width !== e.w)
        $display("FAIL meas_to_width: got %0d want %0d", bif.width, e.w);
      else n_pass++;
    end
    repeat (5) tick();
    do_start();
    sb.push_back('{1'b1, last_w});
    wait_trig_fall(n);
    wait_pulse(n, got);
    n_checks++;
    if (!got) $display("FAIL stuck_pulse: got none want timeout");
    else begin
      n_pass++;
      e = sb.pop_front();
      n_checks++;
      if ({bif.valid, bif.timeout} !== {~e.is_to, e.is_to} || n != TMO)
        $display("FAIL stuck_to: got %b at %0d want %b at %0d",
                 {bif.valid, bif.timeout}, n, {~e.is_to, e.is_to}, TMO);
      else n_pass++;
    end
    bif.echo = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_wrap();
    int n;
    bit got;
    exp_t e;
    load_val = 32'hFFFF_FFF0 - 32'd13;
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    do_start();
    sb.push_back('{1'b0, 32'd40});
    wait_trig_fall(n);
    bif.echo = 1'b1;
    repeat (40) tick();
    bif.echo = 1'b0;
    wait_pulse(n, got);
    n_checks++;
    if (!got) $display("FAIL wrap_pulse: got none want valid");
    else begin
      n_pass++;
      e = sb.pop_front();
      n_checks++;
      if (bif.valid !== ~e.is_to || bif.width !== e.w)
        $display("FAIL wrap_width: got v%b %0d want v1 %0d",
                 bif.valid, bif.width, e.w);
      else n_pass++;
      last_w = e.w;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    bit got;
    exp_t e;
    do_start();
    sb.push_back('{1'b0, 32'd30});
    repeat (3) tick();
    do_start();
    wait_trig_fall(n);
    n_checks++;
    if (n != TRIG - 4)
      $display("FAIL busy_trig_len: got %0d want %0d", n, TRIG - 4);
    else n_pass++;
    bif.echo = 1'b1;
    repeat (10) tick();
    do_start();
    repeat (19) tick();
    bif.echo  = 1'b0;
    bif.start = 1'b1;
    wait_pulse(n, got);
    n_checks++;
    if (!got) $display("FAIL b2b_pulse: got none want valid");
    else begin
      n_pass++;
      e = sb.pop_front();
      n_checks++;
      if (bif.valid !== ~e.is_to || bif.width !== e.w)
        $display("FAIL b2b_width: got v%b %0d want v1 %0d",
                 bif.valid, bif.width, e.w);
      else n_pass++;
      last_w = e.w;
    end
    tick();
    n_checks++;
    if (bif.busy !== 1'b0)
      $display("FAIL b2b_ignore: got busy %b want 0", bif.busy);
    else n_pass++;
    tick();
    bif.start = 1'b0;
    sb.push_back('{1'b1, last_w});
    n_checks++;
    if (bif.busy !== 1'b1)
      $display("FAIL b2b_accept: got busy %b want 1", bif.busy);
    else n_pass++;
    wait_pulse(n, got);
    n_checks++;
    if (!got) $display("FAIL b2b_to_pulse: got none want timeout");
    else begin
      n_pass++;
      e = sb.pop_front();
      n_checks++;
      if (bif.timeout !== e.is_to || bif.width !== e.w)
        $display("FAIL b2b_to: got t%b %0d want t1 %0d",
                 bif.timeout, bif.width, e.w);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int n;
    int pulses;
    bit got;
    exp_t e;
    do_start();
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (bif.trig !== 1'b0 || bif.busy !== 1'b0)
      $display("FAIL rst_trig_drop: got trig %b busy %b want 0 0",
               bif.trig, bif.busy);
    else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    do_start();
    wait_trig_fall(n);
    bif.echo = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (bif.busy !== 1'b1)
      $display("FAIL rst_meas_busy: got %b want 1", bif.busy);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bif.trig !== 1'b0 || bif.busy !== 1'b0 || bif.width !== 32'd0)
      $display("FAIL rst_meas: got trig %b busy %b w %0d want 0 0 0",
               bif.trig, bif.busy, bif.width);
    else n_pass++;
    tick();
    rst = 1'b0;
    last_w = '0;
    pulses = 0;
    repeat (300) begin
      tick();
      if (bif.valid === 1'b1 || bif.timeout === 1'b1) pulses++;
    end
    bif.echo = 1'b0;
    n_checks++;
    if (pulses != 0)
      $display("FAIL rst_no_pulse: got %0d pulses want 0", pulses);
    else n_pass++;
    repeat (4) tick();
    do_start();
    sb.push_back('{1'b0, 32'd33});
    wait_trig_fall(n);
    repeat (5) tick();
    bif.echo = 1'b1;
    repeat (33) tick();
    bif.echo = 1'b0;
    wait_pulse(n, got);
    n_checks++;
    if (!got) $display("FAIL post_rst_pulse: got none want valid");
    else begin
      n_pass++;
      e = sb.pop_front();
      n_checks++;
      if (bif.valid !== ~e.is_to || bif.width !== e.w)
        $display("FAIL post_rst_width: got v%b %0d want v1 %0d",
                 bif.valid, bif.width, e.w);
      else n_pass++;
    end
    tick();
  endtask

  initial begin
    bif.start = 1'b0;
    bif.echo  = 1'b0;
    test_reset();
    test_trig_rise_timeout();
    test_nominal();
    test_echo_timeouts();
    test_wrap();
    test_back_to_back();
    test_reset_mid_op();
    n_checks++;
    if (sb.size() != 0)
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
